// File: rtl/cla_multiword_sequencer.sv
// Multi-precision add/subtract engine: one shared 8-bit CLA slice,
// LSB slice first, carry chained through a register, start/busy/done.
//
// ClaAdder ports: InputA/InputB (8b), InputCarry -> Sum (8b), OutputCarry.
// cla_multiword_sequencer ports:
//   Clock, Reset (sync, active-high), Start, Subtract, InputCarry,
//   InputA/InputB (WORDS*8) -> Busy, Done, Sum (WORDS*8), OutputCarry,
//   Overflow (signed overflow of the full-width operation).

module ClaAdder (
    input  logic [7:0] InputA,
    input  logic [7:0] InputB,
    input  logic       InputCarry,
    output logic [7:0] Sum,
    output logic       OutputCarry
);
    logic [7:0] gen;
    logic [7:0] prop;
    logic [8:0] carry;

    assign gen  = InputA & InputB;
    assign prop = InputA ^ InputB;

    // AND of prop[lo..hi]; flattened so every carry is a two-level term
    function automatic logic spanAnd(
        input logic [7:0] p,
        input int         lo,
        input int         hi
    );
        logic r;
        r = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k >= lo && k <= hi) r &= p[k];
        end
        return r;
    endfunction

    always_comb begin
        carry    = '0;
        carry[0] = InputCarry;
        for (int i = 0; i < 8; i++) begin
            carry[i+1] = gen[i] | (InputCarry & spanAnd(prop, 0, i));
            for (int j = 0; j < i; j++) begin
                carry[i+1] |= gen[j] & spanAnd(prop, j + 1, i);
            end
        end
    end

    assign Sum         = prop ^ carry[7:0];
    assign OutputCarry = carry[8];
endmodule

module cla_multiword_sequencer #(
    parameter int WORDS = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Subtract,
    input  logic [WORDS*8-1:0] InputA,
    input  logic [WORDS*8-1:0] InputB,
    input  logic               InputCarry,
    output logic               Busy,
    output logic               Done,
    output logic [WORDS*8-1:0] Sum,
    output logic               OutputCarry,
    output logic               Overflow
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateType;

    stateType               state;
    logic [WORDS-1:0][7:0]  opA;
    logic [WORDS-1:0][7:0]  opB;
    logic [WORDS-1:0][7:0]  acc;
    logic [WORDS-1:0][7:0]  accNext;
    logic [IW-1:0]          index;
    logic                   carryReg;
    logic [7:0]             sliceSum;
    logic                   sliceCarry;

    ClaAdder slice (
        .InputA      (opA[index]),
        .InputB      (opB[index]),
        .InputCarry  (carryReg),
        .Sum         (sliceSum),
        .OutputCarry (sliceCarry)
    );

    // accumulator including the slice being produced this cycle,
    // so the final slice can go straight to Sum on DONE entry
    always_comb begin
        accNext        = acc;
        accNext[index] = sliceSum;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Sum         <= '0;
            OutputCarry <= 1'b0;
            Overflow    <= 1'b0;
            index       <= '0;
            carryReg    <= 1'b0;
            opA         <= '0;
            opB         <= '0;
            acc         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        opA      <= InputA;
                        opB      <= Subtract ? ~InputB : InputB;
                        // subtract is A + ~B + 1
                        carryReg <= Subtract | InputCarry;
                        index    <= '0;
                        Busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc      <= accNext;
                    carryReg <= sliceCarry;
                    if (index == LAST) begin
                        Sum         <= accNext;
                        OutputCarry <= sliceCarry;
                        Overflow    <= (opA[WORDS-1][7] == opB[WORDS-1][7])
                                    && (sliceSum[7] != opA[WORDS-1][7]);
                        Done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Randomized self-checking bench for cla_multiword_sequencer with a
// timeline-based behavioural model plus directed literal checks.

module tb_cla_multiword_sequencer;
    localparam int WORDS = 4;
    localparam int W     = WORDS * 8;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic         Subtract;
    logic         InputCarry;
    logic [W-1:0] InputA;
    logic [W-1:0] InputB;
    logic [W-1:0] Sum;
    logic         Busy;
    logic         Done;
    logic         OutputCarry;
    logic         Overflow;

    always #5 Clock = ~Clock;

    cla_multiword_sequencer #(.WORDS(WORDS)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Subtract    (Subtract),
        .InputA      (InputA),
        .InputB      (InputB),
        .InputCarry  (InputCarry),
        .Busy        (Busy),
        .Done        (Done),
        .Sum         (Sum),
        .OutputCarry (OutputCarry),
        .Overflow    (Overflow)
    );

    int checks    = 0;
    int passes    = 0;
    int doneCount = 0;
    bit checkEn   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference arithmetic straight from the operation's meaning:
    // unsigned carry / no-borrow, signed range check for overflow.
    function automatic void calc(
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        input  logic         sub,
        input  logic         cin,
        output logic [W-1:0] s,
        output logic         c,
        output logic         o
    );
        logic signed [W+1:0] sa, sb, r;
        logic [W:0] u;
        sa = {{2{a[W-1]}}, a};
        sb = {{2{b[W-1]}}, b};
        if (sub) begin
            r = sa - sb;
            c = (a >= b);
            s = a - b;
        end else begin
            r = sa + sb + (W+2)'(cin);
            u = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            c = u[W];
            s = u[W-1:0];
        end
        o = (r[W+1:W-1] != 3'b000) && (r[W+1:W-1] != 3'b111);
    endfunction

    // Model: an accepted request at edge t yields results at edge
    // t+WORDS and the engine is free again after edge t+WORDS+1.
    int           cyc = 0;
    int           acceptEdge = 0;
    bit           active = 1'b0;
    logic         mBusy = 1'b0, mDone = 1'b0, mC = 1'b0, mO = 1'b0;
    logic [W-1:0] mSum = '0;
    logic [W-1:0] pS;
    logic         pC, pO;

    always @(posedge Clock) begin
        cyc++;
        if (Reset) begin
            active = 1'b0;
            mBusy  = 1'b0;
            mDone  = 1'b0;
            mSum   = '0;
            mC     = 1'b0;
            mO     = 1'b0;
        end else if (active && cyc == acceptEdge + WORDS) begin
            mSum  = pS;
            mC    = pC;
            mO    = pO;
            mDone = 1'b1;
        end else if (active && cyc == acceptEdge + WORDS + 1) begin
            active = 1'b0;
            mBusy  = 1'b0;
            mDone  = 1'b0;
        end else if (!active && Start) begin
            calc(InputA, InputB, Subtract, InputCarry, pS, pC, pO);
            acceptEdge = cyc;
            active     = 1'b1;
            mBusy      = 1'b1;
        end
    end

    always @(negedge Clock) begin
        if (checkEn) begin
            if (Done) doneCount++;
            chk("cycle {busy,done,c,ovf,sum}",
                {Busy, Done, OutputCarry, Overflow, Sum},
                {mBusy, mDone, mC, mO, mSum});
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic cin);
        InputA     = a;
        InputB     = b;
        Subtract   = sub;
        InputCarry = cin;
        Start      = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic waitDone(input string name, input logic [W-1:0] es,
                            input logic ec, input logic eo);
        int n = 0;
        while (!Done && n < WORDS + 4) begin
            tick();
            n++;
        end
        chk({name, " done-seen"}, 64'(Done), 64'(1));
        chk({name, " sum"}, 64'(Sum), 64'(es));
        chk({name, " carry"}, 64'(OutputCarry), 64'(ec));
        chk({name, " ovf"}, 64'(Overflow), 64'(eo));
    endtask

    task automatic runOp(input string name, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sub,
                         input logic cin, input logic [W-1:0] es,
                         input logic ec, input logic eo);
        startOp(a, b, sub, cin);
        waitDone(name, es, ec, eo);
        tick();
    endtask

    initial begin
        logic [W-1:0] s;
        logic c, o;
        int d0;

        Reset = 1'b1; Start = 1'b0; Subtract = 1'b0; InputCarry = 1'b0;
        InputA = '0; InputB = '0;

        // pin the reference arithmetic itself
        calc(32'd5, 32'd12, 1'b0, 1'b0, s, c, o);
        chk("model 5+12", {s, c, o}, {32'd17, 1'b0, 1'b0});
        calc(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, s, c, o);
        chk("model max+1", {s, c, o}, {32'h80000000, 1'b0, 1'b1});
        calc(32'd5, 32'd12, 1'b1, 1'b1, s, c, o);
        chk("model 5-12", {s, c, o}, {32'hFFFFFFF9, 1'b0, 1'b0});

        tick();
        checkEn = 1'b1;
        tick();
        chk("reset state", {Busy, Done, OutputCarry, Overflow, Sum},
            {4'b0000, 32'd0});
        Reset = 1'b0;
        tick();

        // latency / handshake timing
        startOp(32'd5, 32'd12, 1'b0, 1'b0);
        chk("busy after start", 64'(Busy), 64'(1));
        for (int i = 1; i < WORDS; i++) begin
            tick();
            chk("no early done", 64'(Done), 64'(0));
        end
        tick();
        chk("done at edge WORDS", {Done, Sum, OutputCarry, Overflow},
            {1'b1, 32'd17, 1'b0, 1'b0});
        tick();
        chk("done one cycle", {Done, Busy}, 2'b00);

        runOp("ffff+1", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        runOp("80+7f+1", 32'h80, 32'h7F, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        runOp("max+1", 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0,
              32'h80000000, 1'b0, 1'b1);
        runOp("min+min", 32'h80000000, 32'h80000000, 1'b0, 1'b0,
              32'd0, 1'b1, 1'b1);
        runOp("5-12", 32'd5, 32'd12, 1'b1, 1'b1, 32'hFFFFFFF9, 1'b0, 1'b0);
        runOp("12-5", 32'd12, 32'd5, 1'b1, 1'b0, 32'd7, 1'b1, 1'b0);

        // Start held high through RUN and DONE must be ignored
        d0 = doneCount;
        startOp(32'd5, 32'd12, 1'b0, 1'b0);
        InputA = 32'd100; InputB = 32'd200; Start = 1'b1;
        waitDone("ignore start", 32'd17, 1'b0, 1'b0);
        tick();
        Start = 1'b0;
        tick();
        tick();
        chk("ignore idle", 64'(Busy), 64'(0));
        chk("ignore one done", 64'(doneCount - d0), 64'(1));

        // reset during the third RUN cycle aborts the operation
        d0 = doneCount;
        startOp(32'd1000, 32'd2000, 1'b0, 1'b0);
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort state", {Busy, Done, Sum}, {2'b00, 32'd0});
        for (int i = 0; i < WORDS + 2; i++) tick();
        chk("abort no done", 64'(doneCount - d0), 64'(0));
        runOp("after abort", 32'd1000, 32'd2000, 1'b0, 1'b0,
              32'd3000, 1'b0, 1'b0);

        // random traffic: start spam, occasional reset, corner operands
        d0 = doneCount;
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] corner [4];
            corner[0] = '0;
            corner[1] = '1;
            corner[2] = 32'h80000000;
            corner[3] = 32'h7FFFFFFF;
            InputA = ($urandom_range(0, 3) == 0) ?
                     corner[$urandom_range(0, 3)] : W'($urandom);
            InputB = ($urandom_range(0, 3) == 0) ?
                     corner[$urandom_range(0, 3)] : W'($urandom);
            Subtract   = 1'($urandom);
            InputCarry = 1'($urandom);
            Start      = ($urandom_range(0, 2) == 0);
            Reset      = ($urandom_range(0, 99) == 0);
            tick();
        end
        Start = 1'b0;
        Reset = 1'b0;
        for (int i = 0; i < WORDS + 3; i++) tick();
        chk("random ops completed", 64'(doneCount - d0 > 50), 64'(1));

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
